// File: rtl/complement_pkg.sv
// Shared encodings and elaboration helpers for the serial complement unit.
package complement_pkg;

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_ONES = 2'b01;
    localparam logic [1:0] MODE_NEG  = 2'b10;
    localparam logic [1:0] MODE_ABS  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic int calc_nslice(input int width, input int slice);
        return width / slice;
    endfunction

    // Slice counter width; a single-slice build still needs a 1-bit counter.
    function automatic int calc_cnt_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/complement_slice.sv
// One SLICE-bit step: conditional invert of the operand slice plus carry-in.
module complement_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] op_i,
    input  logic             invert_i,
    input  logic             cin_i,
    output logic [SLICE-1:0] sum_o,
    output logic             cout_o
);

    logic [SLICE-1:0] opnd_s;

    assign opnd_s          = invert_i ? ~op_i : op_i;
    assign {cout_o, sum_o} = {1'b0, opnd_s} + {{SLICE{1'b0}}, cin_i};

endmodule

// File: rtl/complement_serial.sv
// Multi-cycle pass / ones' complement / negate / abs unit, LSB slice first,
// with a registered carry between slices and a start/busy/done handshake.
module complement_serial
    import complement_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             complement_clk,
    input  logic             complement_rst_n,
    input  logic             complement_start,
    input  logic [1:0]       complement_mode,
    input  logic [WIDTH-1:0] complement_input,
    output logic             complement_busy,
    output logic             complement_done,
    output logic [WIDTH-1:0] complement_output,
    output logic             complement_carry,
    output logic             complement_zero,
    output logic             complement_overflow
);

    localparam int NSLICE = calc_nslice(WIDTH, SLICE);
    localparam int CW     = calc_cnt_width(NSLICE);
    localparam logic [CW-1:0]    LAST_CNT = CW'(NSLICE - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    if ((WIDTH % SLICE) != 0) begin : g_width_check
        $error("complement_serial: WIDTH must be a multiple of SLICE");
    end

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic             cin_q, cin_d;
    logic             invert_q, invert_d;
    logic             neg_q, neg_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             load_s;
    logic             eff_neg_s;
    logic             eff_inv_s;
    logic [SLICE-1:0]       slice_sum_s;
    logic                   slice_cout_s;
    logic [WIDTH+SLICE-1:0] shift_cat_s;
    logic [WIDTH-1:0]       work_shift_s;

    complement_slice #(.SLICE(SLICE)) u_slice (
        .op_i     (opnd_q[SLICE-1:0]),
        .invert_i (invert_q),
        .cin_i    (cin_q),
        .sum_o    (slice_sum_s),
        .cout_o   (slice_cout_s)
    );

    // Abs is resolved to negate or pass from the operand sign at latch time.
    assign eff_neg_s    = (complement_mode == MODE_NEG) ||
                          ((complement_mode == MODE_ABS) && complement_input[WIDTH-1]);
    assign eff_inv_s    = eff_neg_s || (complement_mode == MODE_ONES);
    assign shift_cat_s  = {slice_sum_s, work_q};
    assign work_shift_s = shift_cat_s[WIDTH+SLICE-1:SLICE];

    // Next-state, datapath and result/flag update logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        opnd_d     = opnd_q;
        work_d     = work_q;
        cin_d      = cin_q;
        invert_d   = invert_q;
        neg_d      = neg_q;
        ovf_pend_d = ovf_pend_q;
        out_d      = out_q;
        carry_d    = carry_q;
        zero_d     = zero_q;
        ovf_d      = ovf_q;
        load_s     = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (complement_start) begin
                    load_s  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                work_d = work_shift_s;
                opnd_d = opnd_q >> SLICE;
                cin_d  = slice_cout_s;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                    out_d   = work_shift_s;
                    carry_d = neg_q & slice_cout_s;
                    zero_d  = (work_shift_s == {WIDTH{1'b0}});
                    ovf_d   = ovf_pend_q;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (load_s) begin
            opnd_d     = complement_input;
            work_d     = {WIDTH{1'b0}};
            cnt_d      = {CW{1'b0}};
            invert_d   = eff_inv_s;
            neg_d      = eff_neg_s;
            cin_d      = eff_neg_s;
            ovf_pend_d = eff_neg_s && (complement_input == MOST_NEG);
        end else begin
            ovf_pend_d = ovf_pend_d;
        end
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge complement_clk) begin
        if (!complement_rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CW{1'b0}};
            opnd_q     <= {WIDTH{1'b0}};
            work_q     <= {WIDTH{1'b0}};
            cin_q      <= 1'b0;
            invert_q   <= 1'b0;
            neg_q      <= 1'b0;
            ovf_pend_q <= 1'b0;
            out_q      <= {WIDTH{1'b0}};
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            opnd_q     <= opnd_d;
            work_q     <= work_d;
            cin_q      <= cin_d;
            invert_q   <= invert_d;
            neg_q      <= neg_d;
            ovf_pend_q <= ovf_pend_d;
            out_q      <= out_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign complement_busy     = busy_q;
    assign complement_done     = done_q;
    assign complement_output   = out_q;
    assign complement_carry    = carry_q;
    assign complement_zero     = zero_q;
    assign complement_overflow = ovf_q;

endmodule

// File: tb/tb_complement_serial.sv
// Directed bench: 16/4 instance for the main table and corner cases,
// 16/16 instance for the single-slice latency case.
module tb_complement_serial;

    localparam logic [1:0] M_PASS = 2'b00;
    localparam logic [1:0] M_ONES = 2'b01;
    localparam logic [1:0] M_NEG  = 2'b10;
    localparam logic [1:0] M_ABS  = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start0, start1;
    logic [1:0]  mode0, mode1;
    logic [15:0] in0, in1;
    logic        busy0, busy1, done0, done1;
    logic [15:0] out0, out1;
    logic        carry0, carry1, zero0, zero1, ovf0, ovf1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    complement_serial #(.WIDTH(16), .SLICE(4)) dut (
        .complement_clk      (clk),
        .complement_rst_n    (rst_n),
        .complement_start    (start0),
        .complement_mode     (mode0),
        .complement_input    (in0),
        .complement_busy     (busy0),
        .complement_done     (done0),
        .complement_output   (out0),
        .complement_carry    (carry0),
        .complement_zero     (zero0),
        .complement_overflow (ovf0)
    );

    complement_serial #(.WIDTH(16), .SLICE(16)) dut1 (
        .complement_clk      (clk),
        .complement_rst_n    (rst_n),
        .complement_start    (start1),
        .complement_mode     (mode1),
        .complement_input    (in1),
        .complement_busy     (busy1),
        .complement_done     (done1),
        .complement_output   (out1),
        .complement_carry    (carry1),
        .complement_zero     (zero1),
        .complement_overflow (ovf1)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] opnd;
        logic [15:0] out;
        logic        carry;
        logic        zero;
        logic        ovf;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one operation on the selected instance and check timing and results.
    task automatic run_op(input bit sel, input logic [1:0] m, input logic [15:0] d,
                          input int exp_lat, input logic [15:0] eo, input logic ec,
                          input logic ez, input logic ev, input string tag);
        int lat;
        int busy_n;
        @(negedge clk);
        if (sel) begin start1 = 1'b1; mode1 = m; in1 = d; end
        else     begin start0 = 1'b1; mode0 = m; in0 = d; end
        @(negedge clk);
        if (sel) begin start1 = 1'b0; mode1 = ~m; in1 = ~d; end
        else     begin start0 = 1'b0; mode0 = ~m; in0 = ~d; end
        lat    = 0;
        busy_n = 0;
        while (!(sel ? done1 : done0) && lat < 20) begin
            if (sel ? busy1 : busy0) busy_n++;
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"},  32'(lat),    32'(exp_lat));
        check({tag, " busy_len"}, 32'(busy_n), 32'(exp_lat));
        check({tag, " busy@done"}, {31'd0, sel ? busy1 : busy0}, 32'd0);
        check({tag, " output"},   {16'd0, sel ? out1 : out0}, {16'd0, eo});
        check({tag, " carry"},    {31'd0, sel ? carry1 : carry0}, {31'd0, ec});
        check({tag, " zero"},     {31'd0, sel ? zero1 : zero0},   {31'd0, ez});
        check({tag, " overflow"}, {31'd0, sel ? ovf1 : ovf0},     {31'd0, ev});
    endtask

    initial begin
        int d1;
        int d2;
        int cyc;
        int done_n;
        logic [15:0] last_exp;

        vecs[0]  = '{M_NEG,  16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{M_NEG,  16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{M_ONES, 16'h00F0, 16'hFF0F, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{M_ABS,  16'hFF9C, 16'h0064, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{M_ABS,  16'h0064, 16'h0064, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{M_ABS,  16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{M_PASS, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{M_NEG,  16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{M_ONES, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{M_ONES, 16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{M_NEG,  16'h00FF, 16'hFF01, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        start0 = 1'b0; mode0 = M_PASS; in0 = 16'h0000;
        start1 = 1'b0; mode1 = M_PASS; in1 = 16'h0000;
        repeat (3) @(negedge clk);
        check("reset output", {16'd0, out0}, 32'd0);
        check("reset busy",   {31'd0, busy0}, 32'd0);
        check("reset done",   {31'd0, done0}, 32'd0);
        check("reset flags",  {29'd0, carry0, zero0, ovf0}, 32'd0);
        check("reset out1",   {16'd0, out1}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_op(1'b0, vecs[i].mode, vecs[i].opnd, 4, vecs[i].out,
                   vecs[i].carry, vecs[i].zero, vecs[i].ovf, $sformatf("vec%0d", i));
        end
        last_exp = 16'hFF01;

        // start pulsed mid-run with another operand must be ignored
        @(negedge clk);
        start0 = 1'b1; mode0 = M_NEG; in0 = 16'h0005;
        @(negedge clk);
        start0 = 1'b0; mode0 = M_PASS; in0 = 16'h0100;
        check("hold output in run", {16'd0, out0}, {16'd0, last_exp});
        check("busy in run", {31'd0, busy0}, 32'd1);
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check("hold output in run 2", {16'd0, out0}, {16'd0, last_exp});
        cyc = 0;
        while (!done0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("ignored start done seen", {31'd0, done0}, 32'd1);
        check("ignored start output", {16'd0, out0}, 32'h0000_FFFB);
        @(negedge clk);
        check("ignored start no rerun busy", {31'd0, busy0}, 32'd0);
        check("ignored start no rerun done", {31'd0, done0}, 32'd0);

        // start held high: back-to-back results every NSLICE+1 cycles
        @(negedge clk);
        start0 = 1'b1; mode0 = M_NEG; in0 = 16'h0001;
        d1 = -1; d2 = -1; cyc = 0;
        while (d2 < 0 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (done0) begin
                if (d1 < 0) d1 = cyc;
                else        d2 = cyc;
            end
        end
        start0 = 1'b0;
        check("held start interval", 32'(d2 - d1), 32'd5);
        check("held start output", {16'd0, out0}, 32'h0000_FFFF);
        @(negedge clk);

        // reset during the 2nd RUN cycle aborts the operation
        @(negedge clk);
        start0 = 1'b1; mode0 = M_NEG; in0 = 16'h0007;
        @(negedge clk);
        start0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrun reset output", {16'd0, out0}, 32'd0);
        check("midrun reset busy",   {31'd0, busy0}, 32'd0);
        check("midrun reset done",   {31'd0, done0}, 32'd0);
        check("midrun reset flags",  {29'd0, carry0, zero0, ovf0}, 32'd0);
        rst_n = 1'b1;
        done_n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done0 || busy0) done_n++;
        end
        check("aborted op never completes", 32'(done_n), 32'd0);
        run_op(1'b0, M_NEG, 16'h0003, 4, 16'hFFFD, 1'b0, 1'b0, 1'b0, "post reset neg");

        run_op(1'b1, M_NEG, 16'h1234, 1, 16'hEDCC, 1'b0, 1'b0, 1'b0, "nslice1 neg");
        run_op(1'b1, M_NEG, 16'h0000, 1, 16'h0000, 1'b1, 1'b1, 1'b0, "nslice1 neg0");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
